// File: rtl/nios_ocimem_monitor.sv
// Debug-monitor memory engine: turns JTAG ocimem strobes into single-word
// reads/writes on a waitrequest-style master port to the debug RAM.
module nios_ocimem_monitor #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int unsigned TMO_W = 16;

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mondreg_q, mondreg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              auto_inc_q, auto_inc_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic busy_c;
    logic any_strobe_c;
    logic done_c;
    logic expire_c;

    // Header bits outside the command/address/data fields carry nothing here.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    assign busy_c       = (state_q == RD) || (state_q == WR);
    assign any_strobe_c = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign done_c       = busy_c && !m_waitrequest;
    assign expire_c     = busy_c && m_waitrequest && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    state_d = jdo[34] ? RD : IDLE;
                end else if (take_action_ocimem_b) begin
                    state_d = WR;
                end else if (take_no_action_ocimem_a) begin
                    state_d = RD;
                end
            end
            RD, WR: begin
                if (done_c || expire_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        mondreg_d  = mondreg_q;
        ready_d    = ready_q;
        error_d    = error_q;
        auto_inc_d = auto_inc_q;
        tmo_d      = tmo_q;
        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d     = jdo[ADDR_W+1:2];
                    auto_inc_d = jdo[35];
                    error_d    = 1'b0;
                    ready_d    = !jdo[34];
                    rd_d       = jdo[34];
                    tmo_d      = '0;
                end else if (take_action_ocimem_b) begin
                    wdata_d = jdo[34:3];
                    wr_d    = 1'b1;
                    ready_d = 1'b0;
                    tmo_d   = '0;
                end else if (take_no_action_ocimem_a) begin
                    rd_d    = 1'b1;
                    ready_d = 1'b0;
                    tmo_d   = '0;
                end
            end
            RD, WR: begin
                // Strobes cannot be queued behind an in-flight transfer.
                if (any_strobe_c) begin
                    error_d = 1'b1;
                end
                if (done_c) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                    if (state_q == RD) begin
                        mondreg_d = m_readdata;
                    end
                    if (auto_inc_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (expire_c) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            mondreg_q  <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            auto_inc_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            mondreg_q  <= mondreg_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            auto_inc_q <= auto_inc_d;
            tmo_q      <= tmo_d;
        end
    end

    assign m_address     = addr_q;
    assign m_read        = rd_q;
    assign m_write       = wr_q;
    assign m_writedata   = wdata_q;
    assign MonDReg       = mondreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_nios_ocimem_monitor.sv
// Directed bench for nios_ocimem_monitor against a 64K-word RAM model.
module tb_nios_ocimem_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [15:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    logic [31:0] ram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;
    bit          mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    nios_ocimem_monitor #(.ADDR_W(16), .TIMEOUT(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .m_address               (m_address),
        .m_read                  (m_read),
        .m_write                 (m_write),
        .m_writedata             (m_writedata),
        .m_readdata              (m_readdata),
        .m_waitrequest           (m_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // RAM slave: combinational read, write on an unstalled write cycle.
    assign m_readdata = ram[m_address];
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (m_write && !m_waitrequest) ram[m_address] <= m_writedata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) chk("rd_wr_exclusive", 32'(m_read & m_write), 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic ai, input logic rd, input logic [15:0] addr);
        return {2'b00, ai, rd, 16'h0000, addr, 2'b00};
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        return {3'b000, data, 3'b000};
    endfunction

    task automatic strobe_a(input logic [37:0] d);
        jdo = d; take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0; jdo = '0;
    endtask

    task automatic strobe_b(input logic [37:0] d);
        jdo = d; take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0; jdo = '0;
    endtask

    task automatic strobe_na();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mondreg"}, MonDReg, 32'd0);
        chk({tag, "_ready"}, 32'(monitor_ready), 32'd0);
        chk({tag, "_error"}, 32'(monitor_error), 32'd0);
        chk({tag, "_m_read"}, 32'(m_read), 32'd0);
        chk({tag, "_m_write"}, 32'(m_write), 32'd0);
        chk({tag, "_m_address"}, 32'(m_address), 32'd0);
        chk({tag, "_m_writedata"}, m_writedata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; jdo = '0; m_waitrequest = 1'b0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        step(); step();
        chk_all_zero("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        // 1: load address and read with no wait states
        preload(16'h0010, 32'hDEADBEEF);
        strobe_a(mk_a(1'b0, 1'b1, 16'h0010));
        chk("t1_m_read", 32'(m_read), 32'd1);
        chk("t1_addr", 32'(m_address), 32'h10);
        chk("t1_ready_busy", 32'(monitor_ready), 32'd0);
        step();
        chk("t1_m_read_drop", 32'(m_read), 32'd0);
        chk("t1_mondreg", MonDReg, 32'hDEADBEEF);
        chk("t1_ready", 32'(monitor_ready), 32'd1);
        chk("t1_error", 32'(monitor_error), 32'd0);
        chk("t1_addr_hold", 32'(m_address), 32'h10);

        // 2: auto-increment write burst wrapping past 0xFFFF
        strobe_a(mk_a(1'b1, 1'b0, 16'hFFFE));
        step();
        chk("t2_load_ready", 32'(monitor_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            strobe_b(mk_b(32'(i + 1)));
            chk("t2_m_write", 32'(m_write), 32'd1);
            chk("t2_wdata", m_writedata, 32'(i + 1));
            chk("t2_ready_busy", 32'(monitor_ready), 32'd0);
            step();
            chk("t2_ready", 32'(monitor_ready), 32'd1);
        end
        chk("t2_ram_fffe", ram[16'hFFFE], 32'd1);
        chk("t2_ram_ffff", ram[16'hFFFF], 32'd2);
        chk("t2_ram_0000", ram[16'h0000], 32'd3);
        chk("t2_addr_final", 32'(m_address), 32'h1);

        // 3: streaming read with five wait cycles
        preload(16'h0020, 32'hCAFEF00D);
        strobe_a(mk_a(1'b0, 1'b0, 16'h0020));
        step();
        m_waitrequest = 1'b1;
        strobe_na();
        for (int i = 0; i < 5; i++) begin
            chk("t3_m_read_stall", 32'(m_read), 32'd1);
            chk("t3_addr_stall", 32'(m_address), 32'h20);
            chk("t3_ready_stall", 32'(monitor_ready), 32'd0);
            chk("t3_mondreg_stall", MonDReg, 32'hDEADBEEF);
            step();
        end
        m_waitrequest = 1'b0;
        chk("t3_m_read_6th", 32'(m_read), 32'd1);
        chk("t3_mondreg_6th", MonDReg, 32'hDEADBEEF);
        step();
        chk("t3_m_read_drop", 32'(m_read), 32'd0);
        chk("t3_mondreg", MonDReg, 32'hCAFEF00D);
        chk("t3_ready", 32'(monitor_ready), 32'd1);
        chk("t3_error", 32'(monitor_error), 32'd0);

        // 4: timeout after eight stall cycles
        m_waitrequest = 1'b1;
        strobe_na();
        for (int i = 0; i < 8; i++) begin
            chk("t4_m_read_stall", 32'(m_read), 32'd1);
            step();
        end
        chk("t4_m_read_drop", 32'(m_read), 32'd0);
        chk("t4_error", 32'(monitor_error), 32'd1);
        chk("t4_ready", 32'(monitor_ready), 32'd1);
        chk("t4_mondreg", MonDReg, 32'hCAFEF00D);
        chk("t4_addr", 32'(m_address), 32'h20);
        m_waitrequest = 1'b0;
        strobe_a(mk_a(1'b0, 1'b0, 16'h0030));
        chk("t4_error_clear", 32'(monitor_error), 32'd0);
        chk("t4_addr_load", 32'(m_address), 32'h30);

        // 5: write strobe colliding with a stalled read, then same-cycle a+b
        preload(16'h0030, 32'h12345678);
        m_waitrequest = 1'b1;
        strobe_na();
        strobe_b(mk_b(32'h00000BAD));
        chk("t5_no_write", 32'(m_write), 32'd0);
        chk("t5_read_held", 32'(m_read), 32'd1);
        chk("t5_error", 32'(monitor_error), 32'd1);
        m_waitrequest = 1'b0;
        step();
        chk("t5_read_done", 32'(m_read), 32'd0);
        chk("t5_mondreg", MonDReg, 32'h12345678);
        chk("t5_ready", 32'(monitor_ready), 32'd1);
        chk("t5_error_sticky", 32'(monitor_error), 32'd1);
        chk("t5_wdata_kept", m_writedata, 32'd3);
        chk("t5_ram_kept", ram[16'h0030], 32'h12345678);
        jdo = mk_a(1'b0, 1'b0, 16'h0040);
        take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; jdo = '0;
        chk("t5_ab_addr", 32'(m_address), 32'h40);
        chk("t5_ab_no_write", 32'(m_write), 32'd0);
        chk("t5_ab_error", 32'(monitor_error), 32'd0);
        step();
        chk("t5_ab_ready", 32'(monitor_ready), 32'd1);
        chk("t5_ab_wdata", m_writedata, 32'd3);

        // 6: reset in the middle of a stalled write, then a fresh read
        m_waitrequest = 1'b1;
        strobe_b(mk_b(32'h000055AA));
        chk("t6_m_write", 32'(m_write), 32'd1);
        reset = 1'b1;
        step();
        chk_all_zero("t6_reset");
        reset = 1'b0;
        m_waitrequest = 1'b0;
        preload(16'h0040, 32'hA5A5A5A5);
        strobe_a(mk_a(1'b0, 1'b1, 16'h0040));
        chk("t6_m_read", 32'(m_read), 32'd1);
        chk("t6_addr", 32'(m_address), 32'h40);
        step();
        chk("t6_mondreg", MonDReg, 32'hA5A5A5A5);
        chk("t6_ready", 32'(monitor_ready), 32'd1);
        chk("t6_error", 32'(monitor_error), 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
